r_msg_mem: RTL
==============

Name: r_msg_mem

Overview:
- Check-to-variable (R) message store for the layered LDPC decoder.
- Sits directly downstream of the CNU result packer, which emits three packed words per layer (CNU pairs 0/1, 2/3, 4/5).
- Holds every layer's words for one full iteration and replays them in the same order during the next iteration.
- Tracks write/read address pointers and iteration count, and generates the first-iteration flag consumed by the packer.

Parameters:
- D_WID, 8, soft-message magnitude width; one packed word is MSG_W = 4*D_WID+20 bits (52 at default).
- LAYERS, 4, block rows per codeword; DEPTH = 3*LAYERS words (12 at default).
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= DEPTH.
- ITER_W, 5, iteration counter width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- frame_start_i  in  1  one-cycle pulse: new codeword; clears pointers, iteration state and error flags
- wr_en_i  in  1  write strobe, one word per asserted cycle
- wr_data_i  in  MSG_W  packed word to store
- rd_en_i  in  1  read request
- rd_data_o  out  MSG_W  read word, valid the cycle after rd_en_i
- rd_vld_o  out  1  qualifies rd_data_o
- iter_0_o  out  1  high until the first full pass of DEPTH writes completes
- iter_cnt_o  out  ITER_W  completed write passes, saturating
- rd_err_o  out  1  sticky: read requested while iter_0_o=1
- par_err_o  out  1  sticky parity error; constant 0 when R_MEM_PARITY_EN is undefined

Behaviour:
- Reset values:
  - rd_data_o=0, rd_vld_o=0, iter_0_o=1, iter_cnt_o=0, rd_err_o=0, par_err_o=0.
  - Internal wr_ptr=0, rd_ptr=0. Array contents are not reset.
- Write:
  - When wr_en_i=1, mem[wr_ptr] <= wr_data_i.
  - wr_ptr increments and wraps from DEPTH-1 to 0.
  - On a write at wr_ptr=DEPTH-1: iter_0_o <= 0 and iter_cnt_o increments, saturating at all-ones.
- Read:
  - When rd_en_i=1, rd_data_o <= mem[rd_ptr] and rd_vld_o <= 1 on the next edge; otherwise rd_vld_o <= 0.
  - rd_data_o holds its value when rd_vld_o=0.
  - Latency is exactly 1 cycle. rd_ptr increments and wraps like wr_ptr.
- Read while iter_0_o=1:
  - The access still happens and the pointer still advances.
  - rd_data_o is forced to 0 and rd_err_o is set.
- Simultaneous rd_en_i and wr_en_i to the same address: read-before-write, so the old word is returned.
- No flow control:
  - The producer guarantees at most one write per cycle. Back-to-back strobes are legal every cycle.
  - rd_ptr may lead or lag wr_ptr freely.
- frame_start_i:
  - Takes priority over wr_en_i and rd_en_i in the same cycle; that write/read is discarded.
  - Next state: wr_ptr=0, rd_ptr=0, iter_0_o=1, iter_cnt_o=0, rd_vld_o=0, rd_err_o=0, par_err_o=0.
- Asynchronous reset mid-pass aborts immediately to the reset values; no partial-pass state is retained.
- Pointer arithmetic is compared against DEPTH-1, not 2**ADDR_W-1, so non-power-of-two depths wrap correctly.

Optional Feature:
- R_MEM_PARITY_EN defined:
  - The array is MSG_W+1 wide. The stored bit is the even parity (XOR reduction) of wr_data_i.
  - On each valid read with iter_0_o=0, the recomputed parity is compared with the stored bit; a mismatch sets par_err_o on the same edge as rd_vld_o.
- Undefined: no extra storage; par_err_o is tied to 0.

Decomposition:
- Shared package ldpc_pkg:
  - Constants D_WID, MSG_W, LAYERS, DEPTH.
  - Typedef msg_word_t [MSG_W-1:0].
  - Function clog2 used for ADDR_W checks.
- Sub-module r_msg_ram: simple dual-port synchronous array (one write port, one registered read port, read-before-write), width and depth parameterised.
  - Pointers, iteration logic and flags stay in r_msg_mem.

Test Plan:
- Reset, then 12 writes of 52'h1..52'hC → iter_0_o falls on the edge of the 12th write; iter_cnt_o=1; wr_ptr wraps to 0.
- After the first pass, 12 back-to-back reads → rd_data_o returns 52'h1..52'hC one cycle after each rd_en_i; rd_vld_o high for 12 consecutive cycles.
- rd_en_i and wr_en_i at the same address (old 52'h5, new 52'hAA) → rd_data_o=52'h5; the next read of that address after wrap returns 52'hAA.
- rd_en_i while iter_0_o=1 → rd_data_o=0, rd_vld_o=1, rd_err_o set and sticky until frame_start_i.
- frame_start_i asserted together with wr_en_i mid-pass (wr_ptr=7) → write discarded; next state wr_ptr=0, iter_0_o=1, iter_cnt_o=0, flags cleared.
- With R_MEM_PARITY_EN, force-flip one stored bit at address 3, then read it → par_err_o=1 alongside rd_vld_o; without the macro par_err_o stays 0.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared constants and types for the layered LDPC decoder datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ldpc_pkg;

    localparam int D_WID  = 8;
    localparam int MSG_W  = 4 * D_WID + 20;
    localparam int LAYERS = 4;
    localparam int DEPTH  = 3 * LAYERS;
    localparam int ADDR_W = 4;
    localparam int ITER_W = 5;

    typedef logic [MSG_W-1:0] msg_word_t;

    // Ceiling log2, used to confirm an address width covers the array depth.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/r_msg_mem_if.sv
// R-message store port bundle: write strobe, read request, read return and status.
// Latency: n/a (wiring only).
// Backpressure: none; the producer paces writes, the consumer paces reads.
interface r_msg_mem_if;
    import ldpc_pkg::*;

    logic              frame_start_i;
    logic              wr_en_i;
    msg_word_t         wr_data_i;
    logic              rd_en_i;
    msg_word_t         rd_data_o;
    logic              rd_vld_o;
    logic              iter_0_o;
    logic [ITER_W-1:0] iter_cnt_o;
    logic              rd_err_o;
    logic              par_err_o;

    modport master (
        output frame_start_i, wr_en_i, wr_data_i, rd_en_i,
        input  rd_data_o, rd_vld_o, iter_0_o, iter_cnt_o, rd_err_o, par_err_o
    );

    modport slave (
        input  frame_start_i, wr_en_i, wr_data_i, rd_en_i,
        output rd_data_o, rd_vld_o, iter_0_o, iter_cnt_o, rd_err_o, par_err_o
    );
endinterface

// File: rtl/r_msg_ram.sv
// Simple dual-port array: one write port, one registered read port, read-before-write.
// Latency: read data 1 cycle after i_rd_en; write visible to reads on the following cycle.
// Backpressure: none; both ports accept an access every cycle.
module r_msg_ram #(
    parameter int W     = 52,
    parameter int DEPTH = 12,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [W-1:0]  i_wr_dat,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
`ifdef R_MEM_PARITY_EN
    output logic          o_rd_par_bad,
`endif
    output logic [W-1:0]  o_rd_dat
);

    logic [W-1:0] r_mem [DEPTH];

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    // Registered read port; samples the old word when a write hits the same address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_rd_dat <= '0;
        end else if (i_rd_en) begin
            o_rd_dat <= r_mem[i_rd_addr];
        end
    end

`ifdef R_MEM_PARITY_EN
    // Whole stored word including its parity bit must XOR to zero.
    always_comb begin
        o_rd_par_bad = ^r_mem[i_rd_addr];
    end
`endif

endmodule

// File: rtl/r_msg_mem.sv
// R-message store: keeps one iteration of packed CNU words and replays them in order.
// Latency: 1 cycle from rd_en_i to rd_data_o/rd_vld_o.
// Backpressure: none; optional parity check enabled by defining R_MEM_PARITY_EN.
module r_msg_mem
    import ldpc_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    r_msg_mem_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    if (ADDR_W < clog2(DEPTH)) begin : g_addr_w_check
        $error("ADDR_W too small for DEPTH");
    end

`ifdef R_MEM_PARITY_EN
    localparam int RAM_W = MSG_W + 1;
`else
    localparam int RAM_W = MSG_W;
`endif

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_iter_0;
    logic [ITER_W-1:0] r_iter_cnt;
    logic              r_rd_vld;
    logic              r_rd_err;
    logic              r_rd_zero;
    logic              r_par_err;
    logic              w_wr_go;
    logic              w_rd_go;
    logic [RAM_W-1:0]  w_ram_wr_dat;
    logic [RAM_W-1:0]  w_ram_rd_dat;
    logic              w_par_bad;

    // A frame start swallows any access presented in the same cycle.
    always_comb begin
        w_wr_go = bus.wr_en_i & ~bus.frame_start_i;
        w_rd_go = bus.rd_en_i & ~bus.frame_start_i;
`ifdef R_MEM_PARITY_EN
        w_ram_wr_dat = {^bus.wr_data_i, bus.wr_data_i};
`else
        w_ram_wr_dat = bus.wr_data_i;
`endif
    end

    r_msg_ram #(
        .W     (RAM_W),
        .DEPTH (DEPTH),
        .AW    (ADDR_W)
    ) u_ram (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_wr_en      (w_wr_go),
        .i_wr_addr    (r_wr_ptr),
        .i_wr_dat     (w_ram_wr_dat),
        .i_rd_en      (w_rd_go),
        .i_rd_addr    (r_rd_ptr),
`ifdef R_MEM_PARITY_EN
        .o_rd_par_bad (w_par_bad),
`endif
        .o_rd_dat     (w_ram_rd_dat)
    );

`ifndef R_MEM_PARITY_EN
    assign w_par_bad = 1'b0;
`endif

    // Pointers, iteration tracking and sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_iter_0   <= 1'b1;
            r_iter_cnt <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_err   <= 1'b0;
            r_rd_zero  <= 1'b0;
            r_par_err  <= 1'b0;
        end else if (bus.frame_start_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_iter_0   <= 1'b1;
            r_iter_cnt <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_err   <= 1'b0;
            r_par_err  <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_go;
            if (w_wr_go) begin
                r_wr_ptr <= (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + 1'b1;
                if (r_wr_ptr == LAST_ADDR) begin
                    r_iter_0 <= 1'b0;
                    if (!(&r_iter_cnt)) begin
                        r_iter_cnt <= r_iter_cnt + 1'b1;
                    end
                end
            end
            if (w_rd_go) begin
                r_rd_ptr  <= (r_rd_ptr == LAST_ADDR) ? '0 : r_rd_ptr + 1'b1;
                r_rd_zero <= r_iter_0;
                if (r_iter_0) begin
                    r_rd_err <= 1'b1;
                end else if (w_par_bad) begin
                    r_par_err <= 1'b1;
                end
            end
        end
    end

    // Reads taken before the first full pass return zero instead of stale array contents.
    always_comb begin
        bus.rd_data_o  = r_rd_zero ? '0 : w_ram_rd_dat[MSG_W-1:0];
        bus.rd_vld_o   = r_rd_vld;
        bus.iter_0_o   = r_iter_0;
        bus.iter_cnt_o = r_iter_cnt;
        bus.rd_err_o   = r_rd_err;
        bus.par_err_o  = r_par_err;
    end

endmodule
